// File: rtl/qr_sram_loader_if.sv
// Pixel-stream, SRAM write port and decoder handshake bundle for the QR SRAM loader.
// The slave modport is the loader; the master modport is the pixel source / decoder side.
interface qr_sram_loader_if #(
  parameter int AW = 12
);
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_data;
  logic          pix_ready;
  logic          sram_wen;
  logic [AW-1:0] sram_waddr;
  logic          sram_wdata;
  logic          qr_decode_start;
  logic          qr_decode_finish;
  logic          busy;

  modport master (
    output pix_valid, pix_sof, pix_data, qr_decode_finish,
    input  pix_ready, sram_wen, sram_waddr, sram_wdata, qr_decode_start, busy
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data, qr_decode_finish,
    output pix_ready, sram_wen, sram_waddr, sram_wdata, qr_decode_start, busy
  );
endinterface

// File: rtl/qr_sram_loader.sv
// Loads a raster-order 1-bit pixel frame into SRAM, then kicks the QR decoder and waits for it.
// Optional QR_LOADER_ONES_CNT_EN adds a ones_cnt output counting dark pixels of the frame.
module qr_sram_loader #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12
) (
  input  logic           clk,
  input  logic           srstn,
  qr_sram_loader_if.slave bus
`ifdef QR_LOADER_ONES_CNT_EN
  ,
  output logic [AW:0]    ones_cnt
`endif
);

  localparam int            NPIX     = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t        state;
  logic [AW-1:0] pix_cnt;
  logic          beat_acc;
  logic          do_write;
  logic [AW-1:0] wr_idx;

  assign beat_acc = bus.pix_valid & bus.pix_ready;
  // A sof beat always restarts at address 0; non-sof beats only count while loading.
  assign do_write = beat_acc & (bus.pix_sof | (state == LOAD));
  assign wr_idx   = bus.pix_sof ? '0 : pix_cnt;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state               <= IDLE;
      pix_cnt             <= '0;
      bus.pix_ready       <= 1'b0;
      bus.sram_wen        <= 1'b1;
      bus.sram_waddr      <= '0;
      bus.sram_wdata      <= 1'b0;
      bus.qr_decode_start <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      bus.sram_wen        <= 1'b1;
      bus.qr_decode_start <= 1'b0;
      if (do_write) begin
        bus.sram_wen   <= 1'b0;
        bus.sram_waddr <= wr_idx;
        bus.sram_wdata <= bus.pix_data;
        bus.busy       <= 1'b1;
        // The counter parks on the last index instead of wrapping.
        if (wr_idx == LAST_IDX) begin
          state         <= START;
          pix_cnt       <= LAST_IDX;
          bus.pix_ready <= 1'b0;
        end else begin
          state         <= LOAD;
          pix_cnt       <= wr_idx + 1'b1;
          bus.pix_ready <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            bus.pix_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
          LOAD: begin
            bus.pix_ready <= 1'b1;
          end
          START: begin
            bus.qr_decode_start <= 1'b1;
            bus.pix_ready       <= 1'b0;
            state               <= WAIT;
          end
          WAIT: begin
            if (bus.qr_decode_finish) begin
              state         <= IDLE;
              bus.pix_ready <= 1'b1;
              bus.busy      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef QR_LOADER_ONES_CNT_EN
  // Follows the write port exactly, so it freezes on its own once the frame is complete.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      ones_cnt <= '0;
    end else if (do_write) begin
      ones_cnt <= (bus.pix_sof ? '0 : ones_cnt) + {{AW{1'b0}}, bus.pix_data};
    end
  end
`endif

endmodule
